// File: rtl/etpu_pkg.sv
// etpu_pkg: shared constants for the Wishbone matrix-vector engine.
// Register offsets are expressed as word indices (byte offset >> 2).
package etpu_pkg;

  // Word-index offsets inside the 4 KiB window
  localparam logic [9:0] WORD_CTRL   = 10'h000;
  localparam logic [9:0] WORD_STATUS = 10'h001;
  localparam logic [9:0] WORD_X_BASE = 10'h020;  // byte 0x080
  localparam logic [9:0] WORD_W_BASE = 10'h040;  // byte 0x100
  localparam logic [9:0] WORD_Y_BASE = 10'h080;  // byte 0x200

  // CTRL bit positions
  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_SAT  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    STREAM  = 2'd2
  } state_t;

endpackage

// File: rtl/etpu_mac_lane.sv
// etpu_mac_lane: one signed multiply-accumulate lane.
// Optional clamping of each accumulate when ETPU_SAT_EN is defined;
// otherwise the accumulator wraps modulo 2^ACC_W.
module etpu_mac_lane #(
  parameter int DW    = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    w,
  input  logic [DW-1:0]    x,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] acc_next,
  output logic             sat_hit
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0]        sum;

  assign prod     = (2*DW)'($signed(w)) * (2*DW)'($signed(x));
  assign prod_ext = ACC_W'(prod);

`ifdef ETPU_SAT_EN
  logic [ACC_W:0] sum_wide;
  logic           ovf;
  assign sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
  assign ovf      = sum_wide[ACC_W] != sum_wide[ACC_W-1];
  // Clamp toward the sign of the true (wide) sum on overflow
  always_comb begin
    sum = sum_wide[ACC_W-1:0];
    if (ovf) sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
  assign sat_hit = en & ovf;
`else
  assign sum     = acc + prod_ext;
  assign sat_hit = 1'b0;
`endif

  // Next accumulator value: clear has priority over accumulate
  always_comb begin
    acc_next = acc;
    if (clr)     acc_next = '0;
    else if (en) acc_next = sum;
  end

  // Accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else     acc <= acc_next;
  end

endmodule

// File: rtl/etpu_wb_matvec.sv
// etpu_wb_matvec: Wishbone-slave matrix-vector engine, y = W*x.
// Holds the bus decode, W/x/y storage and the IDLE/COMPUTE/STREAM FSM.
// Optional build macro: ETPU_SAT_EN (saturating accumulate + STATUS.sat).
module etpu_wb_matvec
  import etpu_pkg::*;
#(
  parameter int          LANES     = 4,
  parameter int          DW        = 8,
  parameter int          ACC_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [31:0]              wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [ACC_W-1:0]         out_data,
  output logic [$clog2(LANES)-1:0] out_idx,
  output logic                     out_valid,
  output logic                     busy
);

  localparam int            IW   = $clog2(LANES);
  localparam logic [IW-1:0] LAST = IW'(LANES-1);

  state_t          state_reg;
  logic [IW-1:0]   step_reg;
  logic            start_pend_reg, done_reg, err_reg, sat_reg;
  logic            busy_reg, out_valid_reg, ack_reg;
  logic [IW-1:0]   out_idx_reg;
  logic [31:0]     dat_reg;

  logic [DW-1:0]    w_reg [LANES*LANES];
  logic [DW-1:0]    x_reg [LANES];
  logic [ACC_W-1:0] y_reg [LANES];
  logic [ACC_W-1:0] acc_q [LANES];
  logic [ACC_W-1:0] acc_nx [LANES];
  logic [LANES-1:0] sat_hit;
  logic [DW-1:0]    x_cur;
  logic [31:0]      rd_data;

  logic [9:0] word;
  logic       hit, req, wr, busy_any, is_ctrl, is_x, is_w, start_wr, sat_any, unused_bits;

  assign word     = wbs_adr_i[11:2];
  assign hit      = wbs_adr_i[31:12] == BASE_ADDR[31:12];
  assign req      = wbs_stb_i & wbs_cyc_i & hit & ~ack_reg;
  assign wr       = req & wbs_we_i;
  assign busy_any = (state_reg != IDLE) | start_pend_reg;
  assign is_ctrl  = word == WORD_CTRL;
  assign is_x     = (word >= WORD_X_BASE) && (word < WORD_X_BASE + 10'(LANES));
  assign is_w     = (word >= WORD_W_BASE) && (word < WORD_W_BASE + 10'(LANES*LANES));
  assign start_wr = wr & is_ctrl & wbs_dat_i[CTRL_START];
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i, sat_hit};

  // Current column operand shared by every lane
  always_comb begin
    x_cur = '0;
    for (int k = 0; k < LANES; k++)
      if (step_reg == IW'(k)) x_cur = x_reg[k];
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DW-1:0] w_cur;
    // Row gi, column step of W feeds lane gi
    always_comb begin
      w_cur = '0;
      for (int k = 0; k < LANES; k++)
        if (step_reg == IW'(k)) w_cur = w_reg[gi*LANES + k];
    end
    etpu_mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .clr      (start_pend_reg),
      .en       (state_reg == COMPUTE),
      .w        (w_cur),
      .x        (x_cur),
      .acc      (acc_q[gi]),
      .acc_next (acc_nx[gi]),
      .sat_hit  (sat_hit[gi])
    );
  end

  // Any lane clamped this cycle
  always_comb begin
    sat_any = 1'b0;
    for (int i = 0; i < LANES; i++) sat_any = sat_any | sat_hit[i];
  end

  // Read mux over the register map; unmapped words read 0
  always_comb begin
    rd_data = '0;
    if (word == WORD_STATUS) rd_data = 32'({sat_reg, err_reg, done_reg, busy_reg});
    for (int k = 0; k < LANES; k++)
      if (word == WORD_X_BASE + 10'(k)) rd_data = 32'(x_reg[k]);
    for (int n = 0; n < LANES*LANES; n++)
      if (word == WORD_W_BASE + 10'(n)) rd_data = 32'(w_reg[n]);
    for (int i = 0; i < LANES; i++)
      if (word == WORD_Y_BASE + 10'(i)) rd_data = 32'($signed(y_reg[i]));
  end

  // Wishbone ack/read-data, one transfer per two clocks
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_reg <= 1'b0;
      dat_reg <= '0;
    end else begin
      ack_reg <= req;
      dat_reg <= (req && !wbs_we_i) ? rd_data : '0;
    end
  end

  // Operand storage and result capture; operand writes dropped while busy
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int n = 0; n < LANES*LANES; n++) w_reg[n] <= '0;
      for (int k = 0; k < LANES; k++) x_reg[k] <= '0;
      for (int i = 0; i < LANES; i++) y_reg[i] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++)
        if (wr && !busy_any && word == WORD_X_BASE + 10'(k)) x_reg[k] <= wbs_dat_i[DW-1:0];
      for (int n = 0; n < LANES*LANES; n++)
        if (wr && !busy_any && word == WORD_W_BASE + 10'(n)) w_reg[n] <= wbs_dat_i[DW-1:0];
      // y takes the final sums at the edge that enters STREAM
      if (state_reg == COMPUTE && step_reg == LAST)
        for (int i = 0; i < LANES; i++) y_reg[i] <= acc_nx[i];
    end
  end

  // Control/status: start request, done, sticky err and sat flags
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      start_pend_reg <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      sat_reg        <= 1'b0;
    end else begin
      start_pend_reg <= start_wr && !busy_any;
      if (wr && busy_any && (start_wr || is_x || is_w)) err_reg <= 1'b1;
      if (state_reg == STREAM && step_reg == LAST) done_reg <= 1'b1;
      else if (start_wr && !busy_any) done_reg <= 1'b0;
      else if (wr && is_ctrl && wbs_dat_i[CTRL_CLR_DONE]) done_reg <= 1'b0;
`ifdef ETPU_SAT_EN
      if (start_wr && !busy_any) sat_reg <= 1'b0;
      else if (sat_any)          sat_reg <= 1'b1;
`else
      sat_reg <= 1'b0;
`endif
    end
  end

  // Sequencer: IDLE -> COMPUTE (LANES steps) -> STREAM (LANES beats) -> IDLE
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg     <= IDLE;
      step_reg      <= '0;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start_pend_reg) begin
          state_reg <= COMPUTE;
          step_reg  <= '0;
          busy_reg  <= 1'b1;
        end
        COMPUTE: if (step_reg == LAST) begin
          state_reg     <= STREAM;
          step_reg      <= '0;
          out_valid_reg <= 1'b1;
          out_idx_reg   <= '0;
        end else begin
          step_reg <= step_reg + 1'b1;
        end
        STREAM: if (step_reg == LAST) begin
          state_reg     <= IDLE;
          step_reg      <= '0;
          busy_reg      <= 1'b0;
          out_valid_reg <= 1'b0;
          out_idx_reg   <= '0;
        end else begin
          step_reg    <= step_reg + 1'b1;
          out_idx_reg <= step_reg + 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Streamed result: accumulators hold steady during STREAM
  always_comb begin
    out_data = '0;
    if (out_valid_reg)
      for (int i = 0; i < LANES; i++)
        if (out_idx_reg == IW'(i)) out_data = acc_q[i];
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign busy      = busy_reg;

endmodule
